simd_wb_decode_pipe: RTL and testbench

Pipelined, buffered successor to the SIMD write-enable decoder: accepts one ALU instruction per cycle over a valid/ready handshake and decodes its VCC/VGPR/SGPR write enables plus an illegal-opcode flag. Results queue in a parametrised FIFO toward the SIMD writeback stage. Compared with the previous decoder it adds:
- deterministic enables for unlisted opcodes (no X), plus an illegal flag;
- wavefront-tag carry-through;
- back-pressure and flush;
- an optional illegal-instruction counter.

---
 rtl/simd_wb_decode_pkg.sv | 61 ++++++
 rtl/simd_wb_decode_lut.sv | 73 +++++++
 rtl/simd_wb_decode_pipe.sv | 139 +++++++++++++
 tb/tb_simd_wb_decode_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_wb_decode_pkg.sv
// rtl/simd_wb_decode_pkg.sv - shared constants and types for the SIMD writeback decode pipe
// Purpose: instruction format codes, decode-table opcode constants, destination
//   override encodings and the decoded-enable struct shared by the LUT and the top.
// Ports: none (package).
package simd_wb_decode_pkg;

  localparam int FMT_W  = 8;
  localparam int OP_W   = 12;
  localparam int DEST_W = 12;

  // Format codes carried in instruction bits [31:24]
  localparam logic [FMT_W-1:0] FMT_VOP1  = 8'h01;
  localparam logic [FMT_W-1:0] FMT_VOP2  = 8'h02;
  localparam logic [FMT_W-1:0] FMT_VOPC  = 8'h04;
  localparam logic [FMT_W-1:0] FMT_VOP3A = 8'h08;

  // VOP1
  localparam logic [OP_W-1:0] OP_VOP1_MOV     = 12'h001;
  // VOP2 plain vector writers
  localparam logic [OP_W-1:0] OP_VOP2_000     = 12'h000;
  localparam logic [OP_W-1:0] OP_VOP2_009     = 12'h009;
  localparam logic [OP_W-1:0] OP_VOP2_012     = 12'h012;
  localparam logic [OP_W-1:0] OP_VOP2_013     = 12'h013;
  localparam logic [OP_W-1:0] OP_VOP2_014     = 12'h014;
  localparam logic [OP_W-1:0] OP_VOP2_016     = 12'h016;
  localparam logic [OP_W-1:0] OP_VOP2_018     = 12'h018;
  localparam logic [OP_W-1:0] OP_VOP2_01A     = 12'h01A;
  localparam logic [OP_W-1:0] OP_VOP2_01B     = 12'h01B;
  localparam logic [OP_W-1:0] OP_VOP2_01C     = 12'h01C;
  // VOP2 carry-out ops write VCC and VGPR
  localparam logic [OP_W-1:0] OP_VOP2_CARRY_LO = 12'h025;
  localparam logic [OP_W-1:0] OP_VOP2_CARRY_HI = 12'h028;
  // Compare ranges, shared by VOPC and VOP3A
  localparam logic [OP_W-1:0] OP_CMP_A_LO     = 12'h080;
  localparam logic [OP_W-1:0] OP_CMP_A_HI     = 12'h087;
  localparam logic [OP_W-1:0] OP_CMP_B_LO     = 12'h0C0;
  localparam logic [OP_W-1:0] OP_CMP_B_HI     = 12'h0C7;
  // VOP3A vector writers
  localparam logic [OP_W-1:0] OP_VOP3_109     = 12'h109;
  localparam logic [OP_W-1:0] OP_VOP3_113     = 12'h113;
  localparam logic [OP_W-1:0] OP_VOP3_114     = 12'h114;
  localparam logic [OP_W-1:0] OP_VOP3_11B     = 12'h11B;
  localparam logic [OP_W-1:0] OP_VOP3_R1_LO   = 12'h148;
  localparam logic [OP_W-1:0] OP_VOP3_R1_HI   = 12'h14A;
  localparam logic [OP_W-1:0] OP_VOP3_R2_LO   = 12'h169;
  localparam logic [OP_W-1:0] OP_VOP3_R2_HI   = 12'h16B;

  // VOP3A scalar destination overrides
  localparam logic [DEST_W-1:0] DEST_VCC         = 12'hE01;
  localparam logic [2:0]        DEST_SGPR_PREFIX = 3'b110;

  typedef struct packed {
    logic vcc;
    logic vgpr;
    logic sgpr;
    logic illegal;
  } wb_dec_t;

  localparam int WB_DEC_W = $bits(wb_dec_t);

endpackage

// File: rtl/simd_wb_decode_lut.sv
// rtl/simd_wb_decode_lut.sv - combinational write-enable decode table with VOP3A dest override
// Purpose: maps {format, opcode} to {vcc, vgpr, sgpr, illegal}; unlisted opcodes
//   give all-zero enables with illegal set.
// Ports:
//   fmt            in  8   instruction format field
//   op             in  12  opcode field
//   sgpr_dest_addr in  12  scalar destination encoding (VOP3A override)
//   dec            out     decoded enables + illegal flag
module simd_wb_decode_lut
  import simd_wb_decode_pkg::*;
(
  input  logic [FMT_W-1:0]  fmt,
  input  logic [OP_W-1:0]   op,
  input  logic [DEST_W-1:0] sgpr_dest_addr,
  output wb_dec_t           dec
);

  logic       hit;
  logic [2:0] en;  // {vcc, vgpr, sgpr}
  logic       is_cmp;

  assign is_cmp = (op inside {[OP_CMP_A_LO:OP_CMP_A_HI], [OP_CMP_B_LO:OP_CMP_B_HI]});

  always_comb begin
    hit = 1'b0;
    en  = 3'b000;
    dec = '0;
    case (fmt)
      FMT_VOP1: begin
        if (op == OP_VOP1_MOV) begin hit = 1'b1; en = 3'b010; end
      end
      FMT_VOP2: begin
        if (op inside {OP_VOP2_000, OP_VOP2_009, OP_VOP2_012, OP_VOP2_013, OP_VOP2_014,
                       OP_VOP2_016, OP_VOP2_018, OP_VOP2_01A, OP_VOP2_01B, OP_VOP2_01C}) begin
          hit = 1'b1; en = 3'b010;
        end else if (op inside {[OP_VOP2_CARRY_LO:OP_VOP2_CARRY_HI]}) begin
          hit = 1'b1; en = 3'b110;
        end
      end
      FMT_VOPC: begin
        if (is_cmp) begin hit = 1'b1; en = 3'b100; end
      end
      FMT_VOP3A: begin
        if (is_cmp) begin
          hit = 1'b1; en = 3'b101;
        end else if (op inside {OP_VOP3_109, OP_VOP3_113, OP_VOP3_114, OP_VOP3_11B,
                                [OP_VOP3_R1_LO:OP_VOP3_R1_HI], [OP_VOP3_R2_LO:OP_VOP3_R2_HI]}) begin
          hit = 1'b1; en = 3'b010;
        end
      end
      default: ;
    endcase

    if (!hit) begin
      dec.illegal = 1'b1;
    end else begin
      dec.vcc  = en[2];
      dec.vgpr = en[1];
      dec.sgpr = en[0];
      // VOP3A scalar result goes to VCC or an SGPR depending on the dest encoding
      if (fmt == FMT_VOP3A) begin
        if (sgpr_dest_addr == DEST_VCC) begin
          dec.vcc  = 1'b1;
          dec.sgpr = 1'b0;
        end else if (sgpr_dest_addr[11:9] == DEST_SGPR_PREFIX) begin
          dec.vcc  = 1'b0;
          dec.sgpr = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/simd_wb_decode_pipe.sv
// rtl/simd_wb_decode_pipe.sv - pipelined SIMD writeback decoder with result FIFO, flush and illegal counter
// Purpose: accepts one instruction per cycle, decodes write enables, queues
//   {enables, illegal, wfid, dest} toward writeback.
// Optional feature macro: SIMD_WB_ILLEGAL_CNT_EN (builds the saturating illegal counter).
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready, in_opcode[31:0], in_sgpr_dest_addr[11:0], in_wfid, in_flush
//   out_valid/out_ready, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal,
//   out_wfid, out_sgpr_dest_addr, out_count (occupancy), illegal_cnt
module simd_wb_decode_pipe
  import simd_wb_decode_pkg::*;
#(
  parameter int WFID_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_opcode,
  input  logic [DEST_W-1:0]             in_sgpr_dest_addr,
  input  logic [WFID_W-1:0]             in_wfid,
  input  logic                          in_flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_vcc_wr_en,
  output logic                          out_vgpr_wr_en,
  output logic                          out_sgpr_wr_en,
  output logic                          out_illegal,
  output logic [WFID_W-1:0]             out_wfid,
  output logic [DEST_W-1:0]             out_sgpr_dest_addr,
  output logic [$clog2(FIFO_DEPTH):0]   out_count,
  output logic [CNT_W-1:0]              illegal_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  wb_dec_t lut_dec;
  logic    unused_opcode_bits;

  assign unused_opcode_bits = ^in_opcode[23:12];

  simd_wb_decode_lut u_lut (
    .fmt            (in_opcode[31:24]),
    .op             (in_opcode[11:0]),
    .sgpr_dest_addr (in_sgpr_dest_addr),
    .dec            (lut_dec)
  );

  logic [OCC_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             accept, push, pop;

  wb_dec_t           dec_mem_q  [FIFO_DEPTH];
  logic [WFID_W-1:0] wfid_mem_q [FIFO_DEPTH];
  logic [DEST_W-1:0] dest_mem_q [FIFO_DEPTH];

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = (count_q != OCC_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  // Flush drops both the same-cycle push and pop
  assign push      = accept & ~in_flush;
  assign pop       = out_valid & out_ready & ~in_flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (in_flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: head fields are masked by out_valid
  always_ff @(posedge clk) begin
    if (push) begin
      dec_mem_q[wr_ptr_q]  <= lut_dec;
      wfid_mem_q[wr_ptr_q] <= in_wfid;
      dest_mem_q[wr_ptr_q] <= in_sgpr_dest_addr;
    end
  end

  wb_dec_t head_dec;
  assign head_dec = dec_mem_q[rd_ptr_q];

  assign out_vcc_wr_en      = out_valid & head_dec.vcc;
  assign out_vgpr_wr_en     = out_valid & head_dec.vgpr;
  assign out_sgpr_wr_en     = out_valid & head_dec.sgpr;
  assign out_illegal        = out_valid & head_dec.illegal;
  assign out_wfid           = out_valid ? wfid_mem_q[rd_ptr_q] : '0;
  assign out_sgpr_dest_addr = out_valid ? dest_mem_q[rd_ptr_q] : '0;
  assign out_count          = count_q;

`ifdef SIMD_WB_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  // Counts on the handshake itself, so a flushed illegal instruction still counts
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (accept && lut_dec.illegal && (illegal_cnt_q != '1))
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_cnt_q <= '0;
    else      illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_cnt = illegal_cnt_q;
`else
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_simd_wb_decode_pipe.sv
// tb/tb_simd_wb_decode_pipe.sv - self-checking bench for simd_wb_decode_pipe
module tb_simd_wb_decode_pipe;
  import simd_wb_decode_pkg::FMT_VOP1;
  import simd_wb_decode_pkg::FMT_VOP2;
  import simd_wb_decode_pkg::FMT_VOPC;
  import simd_wb_decode_pkg::FMT_VOP3A;

  localparam int D = 4;
`ifdef SIMD_WB_ILLEGAL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_opcode = '0;
  logic [11:0] in_sgpr_dest_addr = '0;
  logic [5:0]  in_wfid = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal;
  logic [5:0]  out_wfid;
  logic [11:0] out_sgpr_dest_addr;
  logic [2:0]  out_count;
  logic [15:0] illegal_cnt;

  simd_wb_decode_pipe #(.WFID_W(6), .FIFO_DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_sgpr_dest_addr(in_sgpr_dest_addr), .in_wfid(in_wfid), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vcc_wr_en(out_vcc_wr_en), .out_vgpr_wr_en(out_vgpr_wr_en),
    .out_sgpr_wr_en(out_sgpr_wr_en), .out_illegal(out_illegal),
    .out_wfid(out_wfid), .out_sgpr_dest_addr(out_sgpr_dest_addr),
    .out_count(out_count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        vcc, vgpr, sgpr, ill;
    bit [5:0]  wfid;
    bit [11:0] dest;
  } ent_t;

  ent_t      q[$];
  int        m_cnt = 0;
  int        checks = 0;
  int        errors = 0;
  bit [11:0] cand[$] = {12'h000, 12'h001, 12'h002, 12'h009, 12'h011, 12'h012, 12'h014,
                        12'h015, 12'h016, 12'h017, 12'h018, 12'h019, 12'h01A, 12'h01C,
                        12'h01D, 12'h024, 12'h025, 12'h028, 12'h029, 12'h07F, 12'h080,
                        12'h087, 12'h088, 12'h0BF, 12'h0C0, 12'h0C7, 12'h0C8, 12'h109,
                        12'h113, 12'h114, 12'h11B, 12'h148, 12'h14A, 12'h14B, 12'h169,
                        12'h16B, 12'h16C, 12'h3FF};

  function automatic bit in_rng(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Reference decode written straight from the opcode table
  function automatic ent_t ref_decode(bit [7:0] fmt, bit [11:0] op, bit [11:0] dest, bit [5:0] wfid);
    ent_t e;
    int   v;
    bit   legal, cmp;
    v = int'(op);
    e = '{default: 0};
    e.wfid = wfid;
    e.dest = dest;
    legal = 1;
    cmp = in_rng(v, 'h80, 'h87) || in_rng(v, 'hC0, 'hC7);
    if (fmt == FMT_VOP1 && v == 1) e.vgpr = 1;
    else if (fmt == FMT_VOP2 && (v == 0 || v == 'h9 || in_rng(v, 'h12, 'h14) || v == 'h16 ||
                                 v == 'h18 || in_rng(v, 'h1A, 'h1C))) e.vgpr = 1;
    else if (fmt == FMT_VOP2 && in_rng(v, 'h25, 'h28)) begin e.vcc = 1; e.vgpr = 1; end
    else if (fmt == FMT_VOPC && cmp) e.vcc = 1;
    else if (fmt == FMT_VOP3A && cmp) begin e.vcc = 1; e.sgpr = 1; end
    else if (fmt == FMT_VOP3A && (v == 'h109 || v == 'h113 || v == 'h114 || v == 'h11B ||
                                  in_rng(v, 'h148, 'h14A) || in_rng(v, 'h169, 'h16B))) e.vgpr = 1;
    else legal = 0;
    if (!legal) e.ill = 1;
    else if (fmt == FMT_VOP3A) begin
      if (dest == 12'hE01) begin e.vcc = 1; e.sgpr = 0; end
      else if (dest[11:9] == 3'b110) begin e.vcc = 0; e.sgpr = 1; end
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_count", 32'(out_count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() != D));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      chk("head_en", 32'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal}),
          32'({q[0].vcc, q[0].vgpr, q[0].sgpr, q[0].ill}));
      chk("head_wfid", 32'(out_wfid), 32'(q[0].wfid));
      chk("head_dest", 32'(out_sgpr_dest_addr), 32'(q[0].dest));
    end else begin
      chk("empty_en", 32'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal}), 32'h0);
    end
  endtask

  task automatic drive(bit v, bit [7:0] fmt, bit [11:0] op, bit [11:0] dest, bit [5:0] wfid);
    in_valid          = v;
    in_opcode         = {fmt, 12'($urandom), op};
    in_sgpr_dest_addr = dest;
    in_wfid           = wfid;
  endtask

  task automatic drive_rand(bit v);
    bit [7:0]  fmt;
    bit [11:0] op, dest;
    case ($urandom_range(4, 0))
      0: fmt = FMT_VOP1;
      1: fmt = FMT_VOP2;
      2: fmt = FMT_VOPC;
      3: fmt = FMT_VOP3A;
      default: fmt = 8'($urandom);
    endcase
    op = ($urandom_range(3, 0) == 0) ? 12'($urandom) : cand[$urandom_range(cand.size() - 1, 0)];
    case ($urandom_range(2, 0))
      0: dest = 12'hE01;
      1: dest = {3'b110, 9'($urandom)};
      default: dest = 12'($urandom);
    endcase
    drive(v, fmt, op, dest, 6'($urandom));
  endtask

  // One clock: predict from pre-edge inputs, then compare after the edge
  task automatic tick();
    ent_t e;
    ent_t dropped;
    bit   acc, pp;
    acc = in_valid && (q.size() != D);
    pp  = (q.size() != 0) && out_ready;
    e   = ref_decode(in_opcode[31:24], in_opcode[11:0], in_sgpr_dest_addr, in_wfid);
    @(posedge clk);
    #1;
    if (acc && e.ill && CNT_EN && m_cnt != 16'hFFFF) m_cnt++;
    if (in_flush) q.delete();
    else begin
      if (pp) dropped = q.pop_front();
      if (acc) q.push_back(e);
    end
    check_all();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_wfid", 32'(out_wfid), 32'h0);
    chk("rst_dest", 32'(out_sgpr_dest_addr), 32'h0);
    rst = 1'b1;

    // Directed decodes, consumer always ready
    out_ready = 1'b1;
    drive(1, FMT_VOP2, 12'h025, 12'h000, 6'd5);
    tick();
    chk("tp_vop2_025_en", 32'({out_valid, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal}), 32'b11100);
    chk("tp_vop2_025_wfid", 32'(out_wfid), 32'd5);
    drive(1, FMT_VOP3A, 12'h081, 12'hE01, 6'd1);
    tick();
    chk("tp_vop3_e01", 32'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en}), 32'b100);
    drive(1, FMT_VOP3A, 12'h081, 12'hC05, 6'd2);
    tick();
    chk("tp_vop3_c05", 32'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en}), 32'b001);
    drive(1, FMT_VOP3A, 12'h081, 12'h000, 6'd3);
    tick();
    chk("tp_vop3_000", 32'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en}), 32'b101);
    drive(1, FMT_VOP2, 12'h3FF, 12'h000, 6'd4);
    tick();
    chk("tp_illegal", 32'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal}), 32'b0001);
    chk("tp_illegal_cnt", 32'(illegal_cnt), CNT_EN ? 32'd1 : 32'd0);
    drive(0, 8'h0, 12'h0, 12'h0, 6'd0);
    tick();

    // Fill with consumer stalled, then release with input held
    out_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) begin
      drive_rand(1);
      tick();
    end
    chk("full_ready", 32'(in_ready), 32'h0);
    chk("full_count", 32'(out_count), 32'(D));
    out_ready = 1'b1;
    tick();
    chk("unfull_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 2 * D; i++) begin
      drive_rand(1);
      tick();
    end
    drive(0, 8'h0, 12'h0, 12'h0, 6'd0);
    for (int i = 0; i < D + 1; i++) tick();

    // Flush with a same-cycle push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1);
      tick();
    end
    drive(1, FMT_VOP1, 12'h001, 12'h000, 6'd9);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("flush_count", 32'(out_count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    drive(0, 8'h0, 12'h0, 12'h0, 6'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(1, 0) == 1);
      in_flush  = ($urandom_range(15, 0) == 0);
      tick();
    end
    in_flush = 1'b0;

    // Asynchronous reset mid-stream with two entries queued
    out_ready = 1'b0;
    drive(1, FMT_VOP2, 12'h009, 12'h000, 6'd7);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand(1);
      tick();
    end
    drive(0, 8'h0, 12'h0, 12'h0, 6'd0);
    #3;
    rst = 1'b0;
    #1;
    q.delete();
    m_cnt = 0;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_count", 32'(out_count), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    chk("arst_cnt", 32'(illegal_cnt), 32'h0);
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1, FMT_VOPC, 12'h0C7, 12'h123, 6'd11);
    tick();
    drive(0, 8'h0, 12'h0, 12'h0, 6'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
